// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and imem req/ack fetch engine feeding IF/ID, with a one-entry skid buffer.
// Optional FETCH_PERF_CNT_EN adds transfer and dropped-ack counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] discard_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_e;
    state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, addr_q, addr_d, out_pc_q, out_pc_d, instr_q, instr_d;
    logic [31:0] skid_pc_q, skid_pc_d, skid_data_q, skid_data_d;
    logic req_q, req_d, valid_q, valid_d;
    logic ack, free, redirect;
    // an ack only counts while a request is actually on the bus
    assign ack      = imem_ack_i & req_q;
    assign free     = ~valid_q | ~stall_i;
    assign redirect = branch_i & (state_q != IDLE);
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        req_d       = req_q;
        out_pc_d    = out_pc_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        if (redirect) begin
            pc_d    = branch_target_i;
            valid_d = 1'b0;
            instr_d = 32'd0;
            if (req_q && !ack) begin
                state_d = DISCARD;
            end else begin
                state_d = start_i ? FETCH : IDLE;
                req_d   = start_i;
                addr_d  = start_i ? branch_target_i : addr_q;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    valid_d = 1'b0;
                    instr_d = 32'd0;
                    if (start_i) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                FETCH: begin
                    if (ack) begin
                        req_d = 1'b0;
                        pc_d  = pc_q + PC_STEP;
                        if (free) begin
                            out_pc_d = addr_q;
                            instr_d  = imem_data_i;
                            valid_d  = 1'b1;
                            state_d  = start_i ? FETCH : IDLE;
                        end else begin
                            skid_pc_d   = addr_q;
                            skid_data_d = imem_data_i;
                            state_d     = HOLD;
                        end
                    end else begin
                        valid_d = free ? 1'b0 : valid_q;
                        instr_d = free ? 32'd0 : instr_q;
                        if (req_q) begin
                            state_d = start_i ? FETCH : DISCARD;
                        end else if (start_i) begin
                            req_d  = 1'b1;
                            addr_d = pc_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        out_pc_d = skid_pc_q;
                        instr_d  = skid_data_q;
                        valid_d  = 1'b1;
                        state_d  = FETCH;
                    end
                end
                DISCARD: begin
                    if (ack) begin
                        state_d = start_i ? FETCH : IDLE;
                        req_d   = start_i;
                        addr_d  = start_i ? pc_q : addr_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            out_pc_q    <= 32'd0;
            instr_q     <= 32'd0;
            valid_q     <= 1'b0;
            skid_pc_q   <= 32'd0;
            skid_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            out_pc_q    <= out_pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
        end
    end
    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign pc_o        = out_pc_q;
    assign instr_o     = instr_q;
    assign valid_o     = valid_q;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, discard_cnt_q;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_q   <= 32'd0;
            discard_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q   <= fetch_cnt_q + {31'd0, valid_q & ~stall_i};
            discard_cnt_q <= discard_cnt_q + {31'd0, ack & (redirect | (state_q == DISCARD))};
        end
    end
    assign fetch_cnt_o   = fetch_cnt_q;
    assign discard_cnt_o = discard_cnt_q;
`endif
endmodule
